// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch resolution controller with flag-hazard wait and post-redirect flush
//
// Decodes B (opcode 1100, PC-relative) and BR (opcode 1101, register) branches,
// waits for any pending flag write, evaluates the condition for one cycle, and
// on a taken branch redirects fetch and then holds flush for FLUSH_CYCLES cycles.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   instr_valid  instr/pc/reg_target carry a valid decoded instruction
//   instr        [15:12] opcode, [11:9] condition, [8:0] signed word offset
//   pc           byte address of instr
//   reg_target   register-file read value used as the BR target
//   flag_busy    an older flag-writing instruction is still outstanding
//   cond_true    condition evaluator result for cc_cond
//   cc_cond      latched condition code (WAIT and EVAL only, else 0)
//   stall        hold fetch/decode (combinational)
//   redirect     one-cycle pulse in EVAL when the branch is taken
//   redirect_pc  taken-branch target, valid while redirect=1
//   flush        squash younger instructions after a taken branch
//   taken_cnt    taken-branch count (wraps)
//   ntaken_cnt   not-taken-branch count (wraps)

module branch_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  input  logic [15:0] pc,
  input  logic [15:0] reg_target,
  input  logic        flag_busy,
  input  logic        cond_true,
  output logic [2:0]  cc_cond,
  output logic        stall,
  output logic        redirect,
  output logic [15:0] redirect_pc,
  output logic        flush,
  output logic [15:0] taken_cnt,
  output logic [15:0] ntaken_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_EVAL  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  // Down-counter reload: counts FLUSH_CYCLES-1 .. 0 so flush lasts FLUSH_CYCLES cycles.
  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [2:0]  cond_q;
  logic [2:0]  flush_left;
  logic        is_branch;
  logic        accept;
  logic [15:0] b_target;

  // Opcodes 1100 and 1101 share the upper three bits; bit 12 selects BR.
  assign is_branch = (instr[15:13] == 3'b110);
  assign accept    = (state == S_IDLE) && instr_valid && is_branch;

  // pc + 2 + (sign-extended word offset << 1), wrapping at 16 bits.
  assign b_target = pc + 16'd2 + {{6{instr[8]}}, instr[8:0], 1'b0};

  // The target is resolved at accept time so only one 16-bit register is kept.
  // stall, redirect and cc_cond are combinational: stall must react to the
  // instruction in the accept cycle, and redirect to cond_true in EVAL.
  assign stall    = (rst && accept) || (state == S_WAIT);
  assign redirect = (state == S_EVAL) && cond_true;
  assign flush    = (state == S_FLUSH);
  assign cc_cond  = ((state == S_WAIT) || (state == S_EVAL)) ? cond_q : 3'b000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cond_q      <= 3'b000;
      flush_left  <= 3'b000;
      redirect_pc <= 16'h0000;
      taken_cnt   <= 16'h0000;
      ntaken_cnt  <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cond_q      <= instr[11:9];
            redirect_pc <= instr[12] ? reg_target : b_target;
            state       <= flag_busy ? S_WAIT : S_EVAL;
          end
        end
        S_WAIT: begin
          if (!flag_busy) begin
            state <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (cond_true) begin
            taken_cnt  <= taken_cnt + 16'd1;
            flush_left <= FLUSH_LAST;
            state      <= S_FLUSH;
          end else begin
            ntaken_cnt <= ntaken_cnt + 16'd1;
            state      <= S_IDLE;
          end
        end
        S_FLUSH: begin
          if (flush_left == 3'b000) begin
            state <= S_IDLE;
          end else begin
            flush_left <= flush_left - 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - self-checking bench for branch_ctrl
module tb_branch_ctrl;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic [15:0] pc = 16'h0000;
  logic [15:0] reg_target = 16'h0000;
  logic        flag_busy = 1'b0;
  logic        cond_true = 1'b0;
  logic [2:0]  cc_cond;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        flush;
  logic [15:0] taken_cnt;
  logic [15:0] ntaken_cnt;

  branch_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .pc(pc),
    .reg_target(reg_target), .flag_busy(flag_busy), .cond_true(cond_true),
    .cc_cond(cc_cond), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .flush(flush), .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_taken = 0;
  int exp_ntaken = 0;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] rt;
    int          busy;   // cycles flag_busy is high, starting at the accept cycle
    logic        ct;
    logic [15:0] tgt;
    logic [2:0]  cc;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts();
    check("taken_cnt", taken_cnt, exp_taken & 32'hFFFF);
    check("ntaken_cnt", ntaken_cnt, exp_ntaken & 32'hFFFF);
  endtask

  // Starts in IDLE just after a rising edge; ends in IDLE just after a rising edge.
  task automatic run_branch(input vec_t v);
    int b;
    int last;
    b = v.busy;
    last = v.ct ? b + 2 + FC : b + 2;
    for (int k = 0; k <= last; k++) begin
      instr_valid = (k == 0);
      instr = v.instr;
      pc = v.pc;
      reg_target = v.rt;
      flag_busy = (k < b);
      cond_true = v.ct;
      @(negedge clk);
      check("vec_stall", stall, k <= b);
      check("vec_cc", cc_cond, (k >= 1 && k <= b + 1) ? 32'(v.cc) : 32'd0);
      check("vec_redirect", redirect, (k == b + 1) && v.ct);
      if ((k == b + 1) && v.ct) check("vec_redirect_pc", redirect_pc, v.tgt);
      check("vec_flush", flush, v.ct && (k >= b + 2) && (k < b + 2 + FC));
      tick();
    end
    if (v.ct) exp_taken++;
    else exp_ntaken++;
    check_counts();
  endtask

  // Reference model state for the random phase
  bit          m_open;
  bit          m_eval;
  int          m_flush;
  logic [2:0]  m_cc;
  int          m_tgt;
  bit          e_stall, e_red, e_flush, isbr;
  logic [2:0]  e_cc;
  int          off;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{16'hC203, 16'h0010, 16'h0000, 0, 1'b1, 16'h0018, 3'd1};
    vecs[1] = '{16'hC203, 16'h0010, 16'h0000, 0, 1'b0, 16'h0018, 3'd1};
    vecs[2] = '{16'hC203, 16'h0010, 16'h0000, 3, 1'b1, 16'h0018, 3'd1};
    vecs[3] = '{16'hC1FF, 16'h0000, 16'h5555, 0, 1'b1, 16'h0000, 3'd0};
    vecs[4] = '{16'hD400, 16'h0100, 16'hABCE, 1, 1'b1, 16'hABCE, 3'd2};
    vecs[5] = '{16'hC700, 16'h0004, 16'h0000, 2, 1'b1, 16'hFE06, 3'd3};
    vecs[6] = '{16'hCE00, 16'hFFFE, 16'h0000, 0, 1'b1, 16'h0000, 3'd7};

    // Reset state, with a branch presented while in reset
    #2 rst = 1'b0;
    instr_valid = 1'b1;
    instr = 16'hC203;
    @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_redirect", redirect, 0);
    check("rst_flush", flush, 0);
    check("rst_cc", cc_cond, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check_counts();
    tick();
    instr_valid = 1'b0;
    rst = 1'b1;
    tick();

    foreach (vecs[i]) run_branch(vecs[i]);

    // Non-branch opcode is ignored
    instr_valid = 1'b1;
    instr = 16'hE203;
    @(negedge clk);
    check("nonbr_stall", stall, 0);
    tick();
    @(negedge clk);
    check("nonbr_cc", cc_cond, 0);
    check("nonbr_redirect", redirect, 0);
    tick();
    instr_valid = 1'b0;
    check_counts();

    // Back-to-back: branch in the cycle after a not-taken EVAL, no bubble
    instr_valid = 1'b1; instr = 16'hC203; pc = 16'h0010; flag_busy = 1'b0; cond_true = 1'b0;
    @(negedge clk);
    check("b2b_accept1", stall, 1);
    tick();
    instr = 16'hD400; reg_target = 16'h1234;
    @(negedge clk);
    check("b2b_eval1_stall", stall, 0);
    check("b2b_eval1_redirect", redirect, 0);
    check("b2b_eval1_cc", cc_cond, 1);
    tick();
    cond_true = 1'b1;
    @(negedge clk);
    check("b2b_accept2", stall, 1);
    check("b2b_idle_cc", cc_cond, 0);
    tick();
    instr_valid = 1'b0;
    @(negedge clk);
    check("b2b_eval2_redirect", redirect, 1);
    check("b2b_eval2_pc", redirect_pc, 16'h1234);
    check("b2b_eval2_cc", cc_cond, 2);
    tick();
    for (int i = 0; i < FC; i++) begin
      @(negedge clk);
      check("b2b_flush", flush, 1);
      tick();
    end
    exp_ntaken++;
    exp_taken++;
    check_counts();

    // Reset during the first flush cycle
    instr_valid = 1'b1; instr = 16'hC203; pc = 16'h0010; cond_true = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    @(negedge clk);
    check("rstfl_flush_before", flush, 1);
    #2 rst = 1'b0;
    #1;
    check("rstfl_flush_after", flush, 0);
    check("rstfl_taken", taken_cnt, 0);
    check("rstfl_ntaken", ntaken_cnt, 0);
    check("rstfl_redirect", redirect, 0);
    tick();
    rst = 1'b1;
    exp_taken = 0;
    exp_ntaken = 0;
    run_branch(vecs[0]);
    run_branch(vecs[1]);

    // Counter wrap: preload close to the top, then two taken branches
    force dut.taken_cnt = 16'hFFFE;
    #1;
    release dut.taken_cnt;
    exp_taken = 32'hFFFE;
    run_branch(vecs[0]);
    run_branch(vecs[6]);
    check("wrap_zero", taken_cnt, 16'h0000);

    // Randomized phase against the behavioural model
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m_open = 0; m_eval = 0; m_flush = 0; m_cc = 0; m_tgt = 0;
    exp_taken = 0; exp_ntaken = 0;
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = int'($urandom % 4);
      instr_valid = ($urandom % 4) != 0;
      instr[11:0] = 12'($urandom);
      instr[15:12] = (r == 1) ? 4'hD : (r == 2) ? 4'($urandom) : 4'hC;
      pc = 16'($urandom);
      reg_target = 16'($urandom);
      flag_busy = ($urandom % 3) == 0;
      cond_true = ($urandom % 2) == 1;
      rst = ($urandom % 150) != 0;
      @(negedge clk);
      isbr = instr_valid && (instr[15:12] == 4'hC || instr[15:12] == 4'hD);
      e_stall = 0; e_red = 0; e_flush = 0; e_cc = 3'b000;
      if (!rst) begin
        m_open = 0; m_eval = 0; m_flush = 0;
        exp_taken = 0; exp_ntaken = 0;
      end else if (m_flush > 0) begin
        e_flush = 1;
      end else if (m_open && !m_eval) begin
        e_stall = 1; e_cc = m_cc;
      end else if (m_open) begin
        e_cc = m_cc; e_red = cond_true;
      end else begin
        e_stall = isbr;
      end
      check("rnd_stall", stall, e_stall);
      check("rnd_redirect", redirect, e_red);
      check("rnd_flush", flush, e_flush);
      check("rnd_cc", cc_cond, e_cc);
      if (e_red) check("rnd_redirect_pc", redirect_pc, m_tgt);
      check_counts();
      if (rst) begin
        if (m_flush > 0) begin
          m_flush--;
        end else if (m_open && !m_eval) begin
          if (!flag_busy) m_eval = 1;
        end else if (m_open) begin
          m_open = 0;
          m_eval = 0;
          if (cond_true) begin
            exp_taken++;
            m_flush = FC;
          end else begin
            exp_ntaken++;
          end
        end else if (isbr) begin
          m_open = 1;
          m_eval = !flag_busy;
          m_cc = instr[11:9];
          off = int'(instr[8:0]);
          if (off > 255) off -= 512;
          if (instr[15:12] == 4'hD) m_tgt = int'(reg_target);
          else m_tgt = (int'(pc) + 2 + 2 * off) & 32'hFFFF;
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, SHALL set the number of cycles flush is held after a taken branch (legal 1..7).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 instr_valid  input  1  instr/pc/reg_target carry a valid decoded instruction.
REQ-005 instr  input  16  instruction word: [15:12] opcode, [11:9] condition, [8:0] signed word offset.
REQ-006 pc  input  16  byte address of instr.
REQ-007 reg_target  input  16  register-file read value for BR.
REQ-008 flag_busy  input  1  an older flag-writing instruction has not yet written the FLAG register.
REQ-009 cond_true  input  1  condition evaluator result for cc_cond against current flags.
REQ-010 cc_cond  output  3  latched condition code presented to the evaluator.
REQ-011 stall  output  1  hold fetch/decode; upstream consumes instr only at an edge with instr_valid=1 and stall=0.
REQ-012 redirect  output  1  one-cycle pulse: fetch SHALL load redirect_pc.
REQ-013 redirect_pc  output  16  taken-branch target.
REQ-014 flush  output  1  squash instructions younger than the branch.
REQ-015 taken_cnt  output  16  count of taken branches.
REQ-016 ntaken_cnt  output  16  count of not-taken branches.

Function
REQ-017 Branch decode: opcode 4'b1100 = B (PC-relative), 4'b1101 = BR (register); all other opcodes SHALL be ignored.
REQ-018 States: IDLE, WAIT, EVAL, FLUSH; one state per cycle, no other states.
REQ-019 IDLE: when instr_valid and branch, latch condition, pc, offset, reg_target, type; go to WAIT if flag_busy=1, else EVAL.
REQ-020 stall SHALL be combinational: 1 in IDLE when instr_valid and branch, 1 in WAIT, 0 in EVAL and FLUSH (branch is consumed at end of EVAL).
REQ-021 WAIT: remain while flag_busy=1; go to EVAL the cycle after flag_busy is sampled 0.
REQ-022 EVAL: sample cond_true; if 1: redirect=1 for that cycle, taken_cnt+1, go to FLUSH; if 0: ntaken_cnt+1, go to IDLE, no redirect.
REQ-023 B target = pc + 2 + (sign-extended offset << 1), modulo 2^16 (wrap, no overflow signal).
REQ-024 BR target = latched reg_target unchanged.
REQ-025 redirect_pc SHALL be valid whenever redirect=1; value outside redirect is don't-care.
REQ-026 FLUSH: flush=1 for exactly FLUSH_CYCLES consecutive cycles via down-counter, then IDLE.
REQ-027 instr_valid SHALL be ignored in WAIT, EVAL and FLUSH; a branch at instr in the first IDLE cycle after FLUSH is accepted normally.
REQ-028 cc_cond SHALL equal the latched condition from WAIT through EVAL; 3'b000 in IDLE and FLUSH.
REQ-029 Counters SHALL wrap 16'hFFFF -> 16'h0000 silently.
REQ-030 Back-to-back branches: a branch presented in the cycle after a not-taken EVAL SHALL be accepted with no bubble.

Reset
REQ-031 rst=0 SHALL immediately force IDLE; stall, redirect, flush, cc_cond, redirect_pc, taken_cnt, ntaken_cnt SHALL be 0.
REQ-032 rst asserted in WAIT/EVAL/FLUSH SHALL abandon the branch: no redirect, no count update.
REQ-033 After rst releases, first accepted branch SHALL occur no earlier than the first rising edge with rst=1.

Verification
REQ-034 B taken: pc=16'h0010, instr=16'hC203 (cond eq, off +3), flag_busy=0, cond_true=1 -> stall 1 cycle, EVAL redirect=1 with redirect_pc=16'h0018, flush high 2 cycles, taken_cnt=1.
REQ-035 Not-taken: same instr, cond_true=0 -> no redirect, no flush, ntaken_cnt=1, IDLE next cycle.
REQ-036 Flag hazard: flag_busy=1 for 3 cycles after accept -> stall high 4 cycles total, EVAL one cycle after flag_busy falls, cc_cond=3'b001 throughout.
REQ-037 Negative offset/wrap: pc=16'h0000, B offset 9'h1FF (-1) -> redirect_pc=16'h0000; BR with reg_target=16'hABCE -> redirect_pc=16'hABCE.
REQ-038 Reset mid-FLUSH: rst=0 during flush cycle 1 -> flush drops asynchronously, counters read 0, next branch handled normally.
REQ-039 Counter wrap: force 65536 taken branches -> taken_cnt returns to 16'h0000.
